// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch slice.
//   PC_STEP       byte distance between sequential instructions
//   DEF_RESET_PC  default first fetch address after reset
//   fq_entry_t    fetch-queue entry layout {inst, pc} at the default widths;
//                 the top packs entries the same way for any ADDR_W/INST_W.
package if_pkg;

  localparam int          PC_STEP      = 4;
  localparam int          DEF_ADDR_W   = 32;
  localparam int          DEF_INST_W   = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [DEF_INST_W-1:0] inst;
    logic [DEF_ADDR_W-1:0] pc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {inst, pc} entries toward decode.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   flush         drop all entries (takes priority over push/pop)
//   push          write push_data at the tail
//   pop           advance the head (caller guarantees not empty)
//   head_data     current head entry (registered storage, no bypass)
//   count         number of stored entries, 0..DEPTH
//   empty, full   occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers/count define validity.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
  assign empty     = (count == '0);
  assign full      = (count == DEPTH_CNT);

  assert property (@(posedge clk) disable iff (rst || flush) (pop |-> !empty));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: next-PC select, PC register, synchronous I-mem
// request and a small fetch queue toward decode.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   redirect_valid/redirect_pc flush everything and refetch from the target
//                              (target bits [1:0] are ignored)
//   imem_req_valid/addr        read request; memory always accepts
//   imem_rdata                 read data, one cycle after the request
//   id_valid/id_ready          handshake toward decode
//   id_inst, id_pc, id_npc     queue head; id_npc = id_pc + 4, wrapping
//   fq_count                   number of queued entries
// Requests are credit-throttled: a request issues only when the queued
// entries plus the one in flight, less any entry leaving this cycle, leave
// room, so a returning word always has a slot.
module fetch_unit
  import if_pkg::*;
#(
  parameter  int                ADDR_W   = 32,
  parameter  int                INST_W   = 32,
  parameter  logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
  parameter  int                FQ_DEPTH = 4,
  localparam int                CNT_W    = $clog2(FQ_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [INST_W-1:0] id_inst,
  output logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] id_npc,
  output logic [CNT_W-1:0]  fq_count
);

  localparam int                ENTRY_W    = INST_W + ADDR_W;
  localparam logic [CNT_W:0]    DEPTH_LIM  = (CNT_W + 1)'(FQ_DEPTH);
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  logic [ADDR_W-1:0]  fpc;
  logic               inflight;
  logic [ADDR_W-1:0]  inflight_pc;

  logic               deq;
  logic               issue;
  logic               flush;
  logic               push;
  logic               pop;
  logic [CNT_W:0]     occupancy;
  logic [ENTRY_W-1:0] head;
  logic               fifo_empty;
  logic               fifo_full;

  assign deq = id_valid & id_ready;

  // deq implies at least one queued entry, so this never underflows.
  assign occupancy = {1'b0, fq_count}
                   + {{CNT_W{1'b0}}, inflight}
                   - {{CNT_W{1'b0}}, deq};

  assign issue = !rst && !redirect_valid && (occupancy < DEPTH_LIM);

  // A redirect voids the response in flight and any dequeue this cycle.
  assign flush = rst | redirect_valid;
  assign push  = inflight & ~flush;
  assign pop   = deq & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc         <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      fpc      <= redirect_pc & ALIGN_MASK;
      inflight <= 1'b0;
    end else if (issue) begin
      fpc         <= fpc + STEP;
      inflight    <= 1'b1;
      inflight_pc <= fpc;
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH (FQ_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data ({imem_rdata, inflight_pc}),
    .pop       (pop),
    .head_data (head),
    .count     (fq_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign imem_req_valid = issue;
  assign imem_req_addr  = fpc;

  assign id_valid = ~fifo_empty;
  assign id_inst  = head[ENTRY_W-1:ADDR_W];
  assign id_pc    = head[ADDR_W-1:0];
  assign id_npc   = id_pc + STEP;

  // The credit rule must keep a returning word from landing on a full queue.
  assert property (@(posedge clk) disable iff (rst) (push |-> (!fifo_full || pop)));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances run in lockstep on shared controls
// (depth 4 / reset PC 0 and depth 2 / reset PC 0xFFFF_FFF8). A stream-level
// model (queue of fetched PCs, one word in flight, next fetch PC) predicts
// every output each cycle; scenario tasks add fixed-value timing checks.
module tb_fetch_unit;

  typedef struct packed {
    logic        rv;
    logic [31:0] ra;
    logic        iv;
    logic [31:0] ii;
    logic [31:0] ip;
    logic [31:0] np;
    logic [3:0]  cnt;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_ready = 1'b0;

  logic        rv0, rv1, iv0, iv1;
  logic [31:0] ra0, ra1, ii0, ii1, ip0, ip1, np0, np1;
  logic [31:0] rdata0 = 32'h0, rdata1 = 32'h0;
  logic [2:0]  cnt0;
  logic [1:0]  cnt1;

  always #5 clk = ~clk;

  fetch_unit #(.FQ_DEPTH(4)) dut0 (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(rv0), .imem_req_addr(ra0), .imem_rdata(rdata0),
    .id_valid(iv0), .id_ready(id_ready), .id_inst(ii0), .id_pc(ip0), .id_npc(np0),
    .fq_count(cnt0)
  );

  fetch_unit #(.FQ_DEPTH(2), .RESET_PC(32'hFFFF_FFF8)) dut1 (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(rv1), .imem_req_addr(ra1), .imem_rdata(rdata1),
    .id_valid(iv1), .id_ready(id_ready), .id_inst(ii1), .id_pc(ip1), .id_npc(np1),
    .fq_count(cnt1)
  );

  int checks = 0;
  int errors = 0;
  int cyc_no = 0;

  int          dep [2] = '{4, 2};
  logic [31:0] rpc [2] = '{32'h0000_0000, 32'hFFFF_FFF8};
  logic [31:0] mq  [2][8];
  int          msz [2] = '{0, 0};
  bit          minf[2] = '{1'b0, 1'b0};
  logic [31:0] mipc[2];
  logic [31:0] mfpc[2];
  logic [31:0] nxt_rd[2];
  obs_t        act[2];
  obs_t        exp_o[2];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  function automatic obs_t pack(input logic rv, input logic [31:0] ra, input logic iv,
                                input logic [31:0] ii, input logic [31:0] ip,
                                input logic [31:0] np, input logic [3:0] cnt);
    obs_t o;
    o.rv  = rv;
    o.ra  = (rv === 1'b1) ? ra : 32'h0;
    o.iv  = iv;
    o.ii  = (iv === 1'b1) ? ii : 32'h0;
    o.ip  = (iv === 1'b1) ? ip : 32'h0;
    o.np  = (iv === 1'b1) ? np : 32'h0;
    o.cnt = cnt;
    return o;
  endfunction

  function automatic obs_t actual(input int d);
    if (d == 0) return pack(rv0, ra0, iv0, ii0, ip0, np0, {1'b0, cnt0});
    return pack(rv1, ra1, iv1, ii1, ip1, np1, {2'b00, cnt1});
  endfunction

  // Sample mid-cycle, predict, advance the model, then step past the next
  // rising edge and present the memory's response to this cycle's request.
  task automatic cyc();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      bit          deq, iss, req;
      logic [31:0] t, ra;
      deq = (msz[d] > 0) && id_ready;
      iss = !rst && !redirect_valid && (msz[d] + int'(minf[d]) - int'(deq) < dep[d]);
      exp_o[d] = pack(iss, mfpc[d], msz[d] > 0, mem_word(mq[d][0]), mq[d][0],
                      mq[d][0] + 32'd4, 4'(msz[d]));
      act[d] = actual(d);
      req = (d == 0) ? (rv0 === 1'b1) : (rv1 === 1'b1);
      ra  = (d == 0) ? ra0 : ra1;
      nxt_rd[d] = req ? mem_word(ra) : $urandom;
      if (rst) begin
        msz[d] = 0; minf[d] = 1'b0; mfpc[d] = rpc[d];
      end else if (redirect_valid) begin
        t = redirect_pc; t[1:0] = 2'b00;
        msz[d] = 0; minf[d] = 1'b0; mfpc[d] = t;
      end else begin
        if (deq) begin
          for (int i = 0; i < 7; i++) mq[d][i] = mq[d][i+1];
          msz[d]--;
        end
        if (minf[d] && msz[d] < 8) begin
          mq[d][msz[d]] = mipc[d];
          msz[d]++;
        end
        if (iss) begin
          minf[d] = 1'b1; mipc[d] = mfpc[d]; mfpc[d] = mfpc[d] + 32'd4;
        end else begin
          minf[d] = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    rdata0 = nxt_rd[0];
    rdata1 = nxt_rd[1];
    cyc_no++;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0; id_ready = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic test_reset();
    do_reset();
    cyc();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (act[d] !== exp_o[d]) begin
        errors++;
        $display("FAIL reset_model dut%0d cyc %0d got %h expected %h", d, cyc_no, act[d], exp_o[d]);
      end
    end
    checks++;
    if (act[0].iv !== 1'b0 || act[0].rv !== 1'b0 || act[0].cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_state got iv=%b rv=%b cnt=%0d expected 0 0 0", act[0].iv, act[0].rv, act[0].cnt);
    end
  endtask

  task automatic test_stream();
    rst = 1'b0; id_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act[d] !== exp_o[d]) begin
          errors++;
          $display("FAIL stream_model dut%0d cyc %0d got %h expected %h", d, cyc_no, act[d], exp_o[d]);
        end
      end
      if (k == 1) begin
        checks++;
        if (act[0].rv !== 1'b1 || act[0].ra !== 32'h0) begin
          errors++;
          $display("FAIL first_req got rv=%b addr=%h expected 1 00000000", act[0].rv, act[0].ra);
        end
      end
      if (k >= 3) begin
        checks++;
        if (act[0].iv !== 1'b1 || act[0].ip !== 32'(4 * (k - 3)) || act[0].np !== 32'(4 * (k - 2))) begin
          errors++;
          $display("FAIL stream_pc k=%0d got iv=%b pc=%h npc=%h expected pc=%h", k, act[0].iv, act[0].ip, act[0].np, 32'(4 * (k - 3)));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    rst = 1'b0; id_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act[d] !== exp_o[d]) begin
          errors++;
          $display("FAIL stall_model dut%0d cyc %0d got %h expected %h", d, cyc_no, act[d], exp_o[d]);
        end
      end
    end
    checks++;
    if (act[0].cnt !== 4'd4 || act[0].rv !== 1'b0) begin
      errors++;
      $display("FAIL stall_full got cnt=%0d rv=%b expected 4 0", act[0].cnt, act[0].rv);
    end
    id_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act[d] !== exp_o[d]) begin
          errors++;
          $display("FAIL release_model dut%0d cyc %0d got %h expected %h", d, cyc_no, act[d], exp_o[d]);
        end
      end
      checks++;
      if (act[0].iv !== 1'b1 || act[0].ip !== 32'(4 * k)) begin
        errors++;
        $display("FAIL release_order k=%0d got iv=%b pc=%h expected pc=%h", k, act[0].iv, act[0].ip, 32'(4 * k));
      end
      if (k == 0) begin
        checks++;
        if (act[0].rv !== 1'b1 || act[0].ra !== 32'h10) begin
          errors++;
          $display("FAIL release_req got rv=%b addr=%h expected 1 00000010", act[0].rv, act[0].ra);
        end
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    rst = 1'b0; id_ready = 1'b0;
    for (int k = 1; k <= 4; k++) cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    cyc();
    checks++;
    if (act[0].cnt !== 4'd3) begin
      errors++;
      $display("FAIL redir_setup got cnt=%0d expected 3", act[0].cnt);
    end
    redirect_valid = 1'b0; id_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act[d] !== exp_o[d]) begin
          errors++;
          $display("FAIL redir_model dut%0d cyc %0d got %h expected %h", d, cyc_no, act[d], exp_o[d]);
        end
      end
      if (k == 1) begin
        checks++;
        if (act[0].cnt !== 4'd0 || act[0].rv !== 1'b1 || act[0].ra !== 32'h100) begin
          errors++;
          $display("FAIL redir_flush got cnt=%0d rv=%b addr=%h expected 0 1 00000100", act[0].cnt, act[0].rv, act[0].ra);
        end
      end
      if (k == 3) begin
        checks++;
        if (act[0].iv !== 1'b1 || act[0].ip !== 32'h100) begin
          errors++;
          $display("FAIL redir_latency got iv=%b pc=%h expected 1 00000100", act[0].iv, act[0].ip);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rst = 1'b0; id_ready = 1'b1;
    for (int k = 1; k <= 5; k++) cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    cyc();
    checks++;
    if (act[0].iv !== 1'b1) begin
      errors++;
      $display("FAIL b2b_deq_overlap got iv=%b expected 1", act[0].iv);
    end
    redirect_pc = 32'h300;
    cyc();
    redirect_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act[d] !== exp_o[d]) begin
          errors++;
          $display("FAIL b2b_model dut%0d cyc %0d got %h expected %h", d, cyc_no, act[d], exp_o[d]);
        end
      end
      if (k == 3) begin
        checks++;
        if (act[0].iv !== 1'b1 || act[0].ip !== 32'h300) begin
          errors++;
          $display("FAIL b2b_last_wins got iv=%b pc=%h expected 1 00000300", act[0].iv, act[0].ip);
        end
      end
    end
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    cyc();
    redirect_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      if (k == 3) begin
        checks++;
        if (act[0].iv !== 1'b1 || act[0].ip !== 32'h100 || act[1].ip !== 32'h100) begin
          errors++;
          $display("FAIL redir_align got pc0=%h pc1=%h expected 00000100", act[0].ip, act[1].ip);
        end
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    rst = 1'b0; id_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act[d] !== exp_o[d]) begin
          errors++;
          $display("FAIL wrap_model dut%0d cyc %0d got %h expected %h", d, cyc_no, act[d], exp_o[d]);
        end
      end
      if (k == 4) begin
        checks++;
        if (act[1].ip !== 32'hFFFF_FFFC || act[1].np !== 32'h0) begin
          errors++;
          $display("FAIL wrap_npc got pc=%h npc=%h expected fffffffc 00000000", act[1].ip, act[1].np);
        end
      end
      if (k == 5) begin
        checks++;
        if (act[1].iv !== 1'b1 || act[1].ip !== 32'h0) begin
          errors++;
          $display("FAIL wrap_pc got iv=%b pc=%h expected 1 00000000", act[1].iv, act[1].ip);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rst = 1'b0; id_ready = 1'b0;
    for (int k = 1; k <= 8; k++) cyc();
    checks++;
    if (act[0].cnt !== 4'd4 || act[1].cnt !== 4'd2) begin
      errors++;
      $display("FAIL mid_full got cnt0=%0d cnt1=%0d expected 4 2", act[0].cnt, act[1].cnt);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0; id_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act[d] !== exp_o[d]) begin
          errors++;
          $display("FAIL mid_model dut%0d cyc %0d got %h expected %h", d, cyc_no, act[d], exp_o[d]);
        end
      end
      if (k == 1) begin
        checks++;
        if (act[0].cnt !== 4'd0 || act[0].iv !== 1'b0 || act[0].ra !== 32'h0 || act[1].ra !== 32'hFFFF_FFF8) begin
          errors++;
          $display("FAIL mid_reset got cnt=%0d iv=%b ra0=%h ra1=%h expected 0 0 00000000 fffffff8", act[0].cnt, act[0].iv, act[0].ra, act[1].ra);
        end
      end
      if (k >= 3) begin
        checks++;
        if (act[1].iv !== 1'b1 || act[1].ip !== 32'hFFFF_FFF8 + 32'(4 * (k - 3))) begin
          errors++;
          $display("FAIL depth2_rate k=%0d got iv=%b pc=%h expected pc=%h", k, act[1].iv, act[1].ip, 32'hFFFF_FFF8 + 32'(4 * (k - 3)));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst            = ($urandom_range(0, 59) == 0);
      redirect_valid = !rst && ($urandom_range(0, 11) == 0);
      redirect_pc    = $urandom;
      id_ready       = ($urandom_range(0, 3) != 0);
      cyc();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act[d] !== exp_o[d]) begin
          errors++;
          $display("FAIL random_model dut%0d cyc %0d got %h expected %h", d, cyc_no, act[d], exp_o[d]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
